iob_asym_mem_sequencer: RTL and testbench
=========================================

Name: iob_asym_mem_sequencer

Overview:
- Responder for the wide, lane-enabled external-memory interface that the asymmetric width converter drives (R lane enables, MINADDR_W address, R*N-bit data).
- Services each request against a single narrow N-bit physical RAM by issuing one narrow access per enabled lane, one lane per cycle.
- Reassembles read lanes into a wide word and flags completion, letting converters run on narrow-only memory macros at reduced throughput.

Parameters:
- DATA_W, 32, wide data width on the converter side; must equal R*N.
- R, 4, lanes per wide word; power of 2, at least 2.
- ADDR_W, 3, wide word address width.
- N (derived), DATA_W/R, narrow RAM data width.
- RAM_ADDR_W (derived), ADDR_W+$clog2(R), narrow RAM address width.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- arst_i  in  1  asynchronous, active-high reset.
- cke_i  in  1  clock enable; low freezes all state.
- w_en_i  in  R  write lane enables.
- w_addr_i  in  ADDR_W  wide write address.
- w_data_i  in  DATA_W  write data; lane j is bits [j*N +: N].
- r_en_i  in  R  read lane enables.
- r_addr_i  in  ADDR_W  wide read address.
- r_data_o  out  DATA_W  assembled read data.
- r_valid_o  out  1  one-cycle pulse: r_data_o holds a completed read.
- ready_o  out  1  block idle; a request is accepted in this cycle.
- overrun_o  out  1  sticky flag: a request was presented while ready_o=0.
- ram_en_o  out  1  narrow RAM access enable.
- ram_we_o  out  1  narrow RAM write enable (qualified by ram_en_o).
- ram_addr_o  out  RAM_ADDR_W  narrow address = {wide addr, lane index}.
- ram_d_o  out  N  narrow write data.
- ram_d_i  in  N  narrow read data, valid the cycle after a read issue (1-cycle RAM latency).

Behaviour:
- Reset (arst_i=1, any time, including mid-sequence): state IDLE; pending masks, latched addresses/data and r_data_o reg = 0; r_valid_o=0, overrun_o=0, ram_en_o=0, ready_o=1.
- States: IDLE, WRITE, READ, RDONE.
- ready_o = (state==IDLE). ram_* outputs are driven combinationally from registered state only; they have no combinational path from the request inputs.
- Accept: at an edge with cke_i=1, state IDLE and (|w_en_i | |r_en_i):
  - latch both masks, both addresses and w_data_i;
  - clear the r_data_o reg to 0 only if |r_en_i;
  - go to WRITE if |w_en_i, else READ.
- Request with no enabled lanes: no-op; stay in IDLE.
- WRITE: each cycle, lowest set bit j of the pending write mask is issued: ram_en_o=1, ram_we_o=1, ram_addr_o={w_addr,j}, ram_d_o=lane j. Bit j clears at the edge. After the last bit, go to READ if the read mask is nonzero, else IDLE.
- Simultaneous write+read: all writes complete before any read, so a read of the same address returns the newly written lanes.
- READ: each cycle, lowest set bit j of the read mask is issued: ram_en_o=1, ram_we_o=0, ram_addr_o={r_addr,j}. j is stored in a lane pipeline register.
- Capture: on the edge ending the cycle after each read issue, ram_d_i is written into r_data_o lane j. Lanes not enabled stay 0.
- After the last read issue, go to RDONE. RDONE captures the final lane, then goes to IDLE with r_valid_o=1 for exactly that first IDLE cycle. r_data_o holds its value until the next read is accepted.
- Timing, with accept edge ending cycle T, kw write lanes and kr read lanes:
  - writes are issued in cycles T+1 .. T+kw;
  - reads are issued in T+kw+1 .. T+kw+kr;
  - r_valid_o and ready_o are high in T+kw+kr+2;
  - a write-only request returns to ready_o=1 in T+kw+1.
- A new request may be accepted in the same cycle r_valid_o is high.
- Overrun: any request (nonzero lane enables) seen at an edge with ready_o=0 is ignored and sets overrun_o. overrun_o is cleared only by arst_i.
- cke_i=0: all registers hold and ram_en_o is forced to 0. A sequence resumes unchanged when cke_i returns to 1.

Test Plan:
- Reset then idle: assert arst_i mid-cycle -> ready_o=1, r_valid_o=0, ram_en_o=0, r_data_o=0 immediately, before any clock edge.
- Full write: w_en=4'hF, addr=5, data=32'hDDCCBBAA -> 4 RAM writes at addresses 20,21,22,23 with data AA,BB,CC,DD; ready_o low for 4 cycles.
- Partial read: after the full write, r_en=4'b1010, addr=5 -> reads issued at addresses 21 and 23; r_valid_o on cycle T+4 with r_data_o=32'hDD00BB00.
- Simultaneous write+read: w_en=4'b0001 with data lane0=0x11, r_en=4'b0001, same addr=2 -> write at address 8 precedes read at address 8; r_data_o=32'h00000011 on cycle T+3.
- Overrun and cke stall: present a request while busy -> it is ignored and overrun_o=1 stays set. Deassert cke_i for 3 cycles mid-READ -> ram_en_o=0 during the stall and the final r_data_o is unchanged versus the unstalled run.
- Reset mid-sequence: arst_i during WRITE of a 4-lane write after 2 lanes -> immediate IDLE; no further ram_en_o until a new request is accepted.

Source files
------------

// File: rtl/iob_asym_mem_sequencer.sv
// Serves wide lane-enabled write/read requests against one narrow N-bit RAM,
// one lane per cycle, writes before reads, reassembling read lanes into a wide word.
module iob_asym_mem_sequencer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned R      = 4,
    parameter int unsigned ADDR_W = 3
) (
    input  logic                         clk_i,
    input  logic                         arst_i,
    input  logic                         cke_i,
    input  logic [R-1:0]                 w_en_i,
    input  logic [ADDR_W-1:0]            w_addr_i,
    input  logic [DATA_W-1:0]            w_data_i,
    input  logic [R-1:0]                 r_en_i,
    input  logic [ADDR_W-1:0]            r_addr_i,
    output logic [DATA_W-1:0]            r_data_o,
    output logic                         r_valid_o,
    output logic                         ready_o,
    output logic                         overrun_o,
    output logic                         ram_en_o,
    output logic                         ram_we_o,
    output logic [ADDR_W+$clog2(R)-1:0]  ram_addr_o,
    output logic [DATA_W/R-1:0]          ram_d_o,
    input  logic [DATA_W/R-1:0]          ram_d_i
);

    localparam int unsigned N      = DATA_W / R;
    localparam int unsigned LANE_W = $clog2(R);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RDONE
    } state_t;

    state_t              r_state;
    logic [R-1:0]        r_w_mask;
    logic [R-1:0]        r_r_mask;
    logic [ADDR_W-1:0]   r_w_addr;
    logic [ADDR_W-1:0]   r_r_addr;
    logic [DATA_W-1:0]   r_w_data;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_rvalid;
    logic                r_overrun;
    logic                r_cap_pend;
    logic [LANE_W-1:0]   r_cap_lane;

    logic                w_req;
    logic [LANE_W-1:0]   w_w_lane;
    logic [LANE_W-1:0]   w_r_lane;
    logic [R-1:0]        w_w_rest;
    logic [R-1:0]        w_r_rest;

    // Index of the lowest set bit; lanes are serviced in ascending order.
    function automatic logic [LANE_W-1:0] f_low_lane(input logic [R-1:0] mask);
        f_low_lane = '0;
        for (int i = int'(R) - 1; i >= 0; i--) begin
            if (mask[i]) f_low_lane = LANE_W'(i);
        end
    endfunction

    assign w_req    = (|w_en_i) | (|r_en_i);
    assign w_w_lane = f_low_lane(r_w_mask);
    assign w_r_lane = f_low_lane(r_r_mask);
    assign w_w_rest = r_w_mask & (r_w_mask - R'(1));
    assign w_r_rest = r_r_mask & (r_r_mask - R'(1));

    assign ready_o   = (r_state == S_IDLE);
    assign r_valid_o = r_rvalid;
    assign overrun_o = r_overrun;
    assign r_data_o  = r_rdata;

    // RAM port decoded from registered state only; cke_i low suppresses the access.
    always_comb begin
        ram_en_o   = 1'b0;
        ram_we_o   = 1'b0;
        ram_addr_o = '0;
        ram_d_o    = '0;
        case (r_state)
            S_WRITE: begin
                ram_en_o   = cke_i;
                ram_we_o   = 1'b1;
                ram_addr_o = {r_w_addr, w_w_lane};
                ram_d_o    = r_w_data[N*w_w_lane +: N];
            end
            S_READ: begin
                ram_en_o   = cke_i;
                ram_addr_o = {r_r_addr, w_r_lane};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state    <= S_IDLE;
            r_w_mask   <= '0;
            r_r_mask   <= '0;
            r_w_addr   <= '0;
            r_r_addr   <= '0;
            r_w_data   <= '0;
            r_rdata    <= '0;
            r_rvalid   <= 1'b0;
            r_overrun  <= 1'b0;
            r_cap_pend <= 1'b0;
            r_cap_lane <= '0;
        end else if (cke_i) begin
            r_rvalid   <= 1'b0;
            r_cap_pend <= 1'b0;
            // RAM data arrives one cycle after its read issue.
            if (r_cap_pend) r_rdata[N*r_cap_lane +: N] <= ram_d_i;
            if (w_req && r_state != S_IDLE) r_overrun <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_w_mask <= w_en_i;
                        r_r_mask <= r_en_i;
                        r_w_addr <= w_addr_i;
                        r_r_addr <= r_addr_i;
                        r_w_data <= w_data_i;
                        if (|r_en_i) r_rdata <= '0;
                        r_state  <= (|w_en_i) ? S_WRITE : S_READ;
                    end
                end
                S_WRITE: begin
                    r_w_mask <= w_w_rest;
                    if (w_w_rest == '0) r_state <= (|r_r_mask) ? S_READ : S_IDLE;
                end
                S_READ: begin
                    r_r_mask   <= w_r_rest;
                    r_cap_pend <= 1'b1;
                    r_cap_lane <= w_r_lane;
                    if (w_r_rest == '0) r_state <= S_RDONE;
                end
                S_RDONE: begin
                    r_state  <= S_IDLE;
                    r_rvalid <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iob_asym_mem_sequencer.sv
// Bench for iob_asym_mem_sequencer: narrow RAM model plus a lane-level reference
// of the expected access schedule and returned read words.
module tb_iob_asym_mem_sequencer;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned R      = 4;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned N      = 8;
    localparam int unsigned RAW    = 5;

    logic              clk_i = 1'b0;
    logic              arst_i;
    logic              cke_i;
    logic [R-1:0]      w_en_i;
    logic [ADDR_W-1:0] w_addr_i;
    logic [DATA_W-1:0] w_data_i;
    logic [R-1:0]      r_en_i;
    logic [ADDR_W-1:0] r_addr_i;
    logic [DATA_W-1:0] r_data_o;
    logic              r_valid_o;
    logic              ready_o;
    logic              overrun_o;
    logic              ram_en_o;
    logic              ram_we_o;
    logic [RAW-1:0]    ram_addr_o;
    logic [N-1:0]      ram_d_o;
    logic [N-1:0]      ram_d_i;

    always #5 clk_i = ~clk_i;

    iob_asym_mem_sequencer #(.DATA_W(DATA_W), .R(R), .ADDR_W(ADDR_W)) dut (
        .clk_i(clk_i), .arst_i(arst_i), .cke_i(cke_i),
        .w_en_i(w_en_i), .w_addr_i(w_addr_i), .w_data_i(w_data_i),
        .r_en_i(r_en_i), .r_addr_i(r_addr_i),
        .r_data_o(r_data_o), .r_valid_o(r_valid_o), .ready_o(ready_o),
        .overrun_o(overrun_o), .ram_en_o(ram_en_o), .ram_we_o(ram_we_o),
        .ram_addr_o(ram_addr_o), .ram_d_o(ram_d_o), .ram_d_i(ram_d_i)
    );

    // Narrow physical RAM, one-cycle read latency, output held while disabled.
    logic [N-1:0] ram [32];
    logic [N-1:0] ram_q;
    always @(posedge clk_i) begin
        if (ram_en_o) begin
            if (ram_we_o) ram[ram_addr_o] <= ram_d_o;
            else          ram_q <= ram[ram_addr_o];
        end
    end
    assign ram_d_i = ram_q;

    logic [N-1:0]  model [32];
    logic [31:0]   last_rd;
    int            n_tests = 0;
    int            n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one request at a ready negedge and follow it lane by lane.
    task automatic run_req(input logic [3:0] wen, input logic [2:0] waddr, input logic [31:0] wdata,
                           input logic [3:0] ren, input logic [2:0] raddr,
                           input int inj_at, input int stall_at, input int stall_len,
                           input int rst_at, output logic [31:0] rd);
        int          nops;
        logic        op_we [8];
        int          op_lane [8];
        logic [4:0]  a;
        logic [31:0] exp;
        rd   = r_data_o;
        nops = 0;
        for (int j = 0; j < 4; j++) if (wen[j]) begin op_we[nops] = 1'b1; op_lane[nops] = j; nops++; end
        for (int j = 0; j < 4; j++) if (ren[j]) begin op_we[nops] = 1'b0; op_lane[nops] = j; nops++; end
        chk("accept_ready", 64'(ready_o), 64'(1));
        w_en_i = wen; w_addr_i = waddr; w_data_i = wdata; r_en_i = ren; r_addr_i = raddr;
        @(negedge clk_i);
        w_en_i = '0; r_en_i = '0; w_addr_i = ~waddr; r_addr_i = ~raddr; w_data_i = ~wdata;
        if (nops == 0) begin
            chk("noop_ready", 64'(ready_o), 64'(1));
            chk("noop_ram_en", 64'(ram_en_o), 64'(0));
            return;
        end
        for (int i = 0; i < nops; i++) begin
            a = 5'(int'(op_we[i] ? waddr : raddr) * 4 + op_lane[i]);
            chk("op_ram_en", 64'(ram_en_o), 64'(1));
            chk("op_ram_we", 64'(ram_we_o), 64'(op_we[i]));
            chk("op_ram_addr", 64'(ram_addr_o), 64'(a));
            chk("op_busy", 64'(ready_o), 64'(0));
            chk("op_valid_low", 64'(r_valid_o), 64'(0));
            if (op_we[i]) begin
                chk("op_ram_d", 64'(ram_d_o), 64'(wdata[op_lane[i]*8 +: 8]));
                chk("rdata_hold", 64'(r_data_o), 64'((ren != 0) ? 32'h0 : last_rd));
            end
            if (i == rst_at) begin
                arst_i = 1'b1;
                #1;
                chk("rst_ready", 64'(ready_o), 64'(1));
                chk("rst_ram_en", 64'(ram_en_o), 64'(0));
                chk("rst_valid", 64'(r_valid_o), 64'(0));
                chk("rst_rdata", 64'(r_data_o), 64'(0));
                chk("rst_overrun", 64'(overrun_o), 64'(0));
                @(negedge clk_i);
                arst_i  = 1'b0;
                last_rd = '0;
                for (int k = 0; k < 3; k++) begin
                    chk("post_rst_ram_en", 64'(ram_en_o), 64'(0));
                    chk("post_rst_ready", 64'(ready_o), 64'(1));
                    @(negedge clk_i);
                end
                rd = r_data_o;
                return;
            end
            if (i == stall_at) begin
                cke_i = 1'b0;
                for (int k = 0; k < stall_len; k++) begin
                    #1;
                    chk("stall_ram_en", 64'(ram_en_o), 64'(0));
                    chk("stall_busy", 64'(ready_o), 64'(0));
                    @(negedge clk_i);
                end
                cke_i = 1'b1;
                #1;
                chk("resume_ram_en", 64'(ram_en_o), 64'(1));
                chk("resume_ram_addr", 64'(ram_addr_o), 64'(a));
            end
            if (i == inj_at) begin
                w_en_i = 4'hF; r_en_i = 4'hF; w_addr_i = 3'd7; r_addr_i = 3'd7;
            end
            if (op_we[i]) model[a] = wdata[op_lane[i]*8 +: 8];
            @(negedge clk_i);
            w_en_i = '0; r_en_i = '0;
        end
        if (ren == 0) begin
            chk("wo_ready", 64'(ready_o), 64'(1));
            chk("wo_valid", 64'(r_valid_o), 64'(0));
        end else begin
            chk("rdone_busy", 64'(ready_o), 64'(0));
            chk("rdone_ram_en", 64'(ram_en_o), 64'(0));
            chk("rdone_valid", 64'(r_valid_o), 64'(0));
            @(negedge clk_i);
            exp = '0;
            for (int j = 0; j < 4; j++) if (ren[j]) exp[j*8 +: 8] = model[raddr*4 + j];
            chk("done_ready", 64'(ready_o), 64'(1));
            chk("done_valid", 64'(r_valid_o), 64'(1));
            chk("done_rdata", 64'(r_data_o), 64'(exp));
            last_rd = exp;
            rd = r_data_o;
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [3:0]  wen, ren;
        int          st;
        arst_i = 1'b0; cke_i = 1'b1;
        w_en_i = '0; w_addr_i = '0; w_data_i = '0; r_en_i = '0; r_addr_i = '0;
        last_rd = '0;
        ram_q = '0;
        for (int i = 0; i < 32; i++) begin model[i] = 8'($urandom); ram[i] = model[i]; end

        #3 arst_i = 1'b1;
        #1;
        chk("reset_ready", 64'(ready_o), 64'(1));
        chk("reset_valid", 64'(r_valid_o), 64'(0));
        chk("reset_ram_en", 64'(ram_en_o), 64'(0));
        chk("reset_rdata", 64'(r_data_o), 64'(0));
        chk("reset_overrun", 64'(overrun_o), 64'(0));
        @(negedge clk_i);
        arst_i = 1'b0;
        @(negedge clk_i);

        run_req(4'h0, 3'd3, 32'h12345678, 4'h0, 3'd3, -1, -1, 0, -1, rd);
        run_req(4'hF, 3'd5, 32'hDDCCBBAA, 4'h0, 3'd0, -1, -1, 0, -1, rd);
        run_req(4'h0, 3'd0, 32'h0, 4'b1010, 3'd5, -1, -1, 0, -1, rd);
        chk("partial_read_word", 64'(rd), 64'(32'hDD00BB00));
        run_req(4'b0001, 3'd2, 32'h00000011, 4'b0001, 3'd2, -1, -1, 0, -1, rd);
        chk("wr_then_rd_word", 64'(rd), 64'(32'h00000011));

        for (int n = 0; n < 40; n++) begin
            wen = 4'($urandom);
            ren = 4'($urandom);
            st  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
            run_req(wen, 3'($urandom), $urandom, ren, 3'($urandom), -1, st,
                    int'($urandom_range(1, 3)), -1, rd);
        end
        chk("no_overrun_yet", 64'(overrun_o), 64'(0));

        run_req(4'h0, 3'd0, 32'h0, 4'hF, 3'd5, 0, 2, 3, -1, rd);
        chk("stalled_read_word", 64'(rd), 64'({model[23], model[22], model[21], model[20]}));
        chk("overrun_set", 64'(overrun_o), 64'(1));
        run_req(4'h0, 3'd0, 32'h0, 4'h0, 3'd0, -1, -1, 0, -1, rd);
        chk("overrun_sticky", 64'(overrun_o), 64'(1));

        run_req(4'hF, 3'd1, 32'hA1B2C3D4, 4'h0, 3'd0, -1, -1, 0, 2, rd);
        chk("overrun_cleared", 64'(overrun_o), 64'(0));
        run_req(4'h0, 3'd0, 32'h0, 4'hF, 3'd1, -1, -1, 0, -1, rd);
        chk("after_rst_lanes", 64'(rd[15:0]), 64'(16'hC3D4));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
